fp16_to_fixed_stream: RTL

Streaming, pipelined FP16-to-signed-fixed-point converter for the accelerator datapath. It accepts LANES half-precision values per beat over a valid/ready handshake and returns LANES two's-complement fixed-point results. Output width and fraction width are parametrised. It adds rounding, saturation, subnormal support and status flags, and sits between the FP16 operand buffers and the fixed-point MAC array.

---
 rtl/fp2fix_pkg.sv | 20 ++
 rtl/fp2fix_lane.sv | 63 ++++++
 rtl/fp16_to_fixed_stream.sv | 63 ++++++
 3 files changed

// File: rtl/fp2fix_pkg.sv
// fp2fix_pkg: shared constants and types for the FP16 to fixed-point converter.
package fp2fix_pkg;
    localparam int FP_W = 16;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS = 15;
    localparam int EXP_MAX = 31;
    // Aligned magnitude holds the largest finite FP16 for FRAC_W up to 32.
    localparam int MAG_W = 48;
    typedef enum logic {RM_TRUNC = 1'b0, RM_RNE = 1'b1} round_mode_e;
    typedef struct packed {
        logic sign;
        logic nan;
        logic inf;
        logic [MAG_W-1:0] mag;
        logic guard;
        logic sticky;
        round_mode_e rm;
    } s1_payload_t;
endpackage

// File: rtl/fp2fix_lane.sv
// fp2fix_lane: one lane of the two-stage FP16 to signed fixed-point datapath.
// S1 decodes and aligns, S2 rounds, saturates, negates and raises flags.
module fp2fix_lane
    import fp2fix_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1_en,
    input  logic             s2_en,
    input  logic [FP_W-1:0]  fp,
    input  round_mode_e      rm,
    output logic [OUT_W-1:0] data,
    output logic             sat,
    output logic             nan
);
    // The aligned word carries value*2^FRAC_W scaled up by 2^LSB, so bit LSB has weight 2^-FRAC_W.
    localparam int LSB = BIAS + MAN_W - 1;
    localparam int WIDE_W = MAN_W + 1 + EXP_MAX - 2 + FRAC_W;
    localparam int RW = MAG_W + 1;
    localparam logic [RW-1:0] LIM = RW'(1) << (OUT_W - 1);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [MAN_W:0] sig;
    logic [WIDE_W-1:0] wide;
    s1_payload_t d1, q1;
    logic inc, ovf;
    logic [RW-1:0] rnd;
    always_comb begin
        e = fp[FP_W-2 -: EXP_W];
        m = fp[MAN_W-1:0];
        sig = {e != '0, m};
        wide = WIDE_W'(sig) << (FRAC_W + 32'(e == '0 ? EXP_W'(0) : e - EXP_W'(1)));
        d1.sign = fp[FP_W-1];
        d1.nan = e == EXP_W'(EXP_MAX) && m != '0;
        d1.inf = e == EXP_W'(EXP_MAX) && m == '0;
        d1.mag = MAG_W'(wide >> LSB);
        d1.guard = wide[LSB-1];
        d1.sticky = |wide[LSB-2:0];
        d1.rm = rm;
        inc = q1.rm == RM_RNE && q1.guard && (q1.sticky || q1.mag[0]);
        rnd = RW'(q1.mag) + RW'(inc);
        // Negative side reaches one further: exactly -2^(OUT_W-1) is representable.
        ovf = q1.inf || (q1.sign ? rnd > LIM : rnd >= LIM);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            data <= '0;
            sat <= 1'b0;
            nan <= 1'b0;
        end else begin
            if (s1_en) q1 <= d1;
            if (s2_en) begin
                data <= q1.nan ? '0 : ovf ? {q1.sign, {(OUT_W-1){!q1.sign}}} : q1.sign ? OUT_W'(-rnd) : OUT_W'(rnd);
                sat <= ovf && !q1.nan;
                nan <= q1.nan;
            end
        end
    end
endmodule

// File: rtl/fp16_to_fixed_stream.sv
// fp16_to_fixed_stream: LANES-wide streaming FP16 to signed fixed-point converter.
// Define FP2FIX_STATS_EN to add the saturating sat_cnt event counter.
module fp16_to_fixed_stream
    import fp2fix_pkg::*;
#(
    parameter int LANES = 1,
    parameter int OUT_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FP_W*LANES-1:0]  in_data,
    input  logic                   round_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    output logic [LANES-1:0]       out_nan
`ifdef FP2FIX_STATS_EN
    ,
    output logic [15:0]            sat_cnt
`endif
);
    logic s1_valid, s2_valid, s1_adv;
    assign s1_adv = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;
    assign out_valid = s2_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s1_adv) s2_valid <= s1_valid;
        end
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp2fix_lane #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) u_lane (
            .clk(clk),
            .rst_n(rst_n),
            .s1_en(in_valid && in_ready),
            .s2_en(s1_valid && s1_adv),
            .fp(in_data[FP_W*i +: FP_W]),
            .rm(round_mode_e'(round_mode)),
            .data(out_data[OUT_W*i +: OUT_W]),
            .sat(out_sat[i]),
            .nan(out_nan[i])
        );
    end
`ifdef FP2FIX_STATS_EN
    logic [16:0] cnt_sum;
    always_comb begin
        cnt_sum = {1'b0, sat_cnt};
        for (int k = 0; k < LANES; k++) cnt_sum = cnt_sum + 17'(out_sat[k]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_cnt <= '0;
        else if (out_valid && out_ready) sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
`endif
endmodule
